// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 schedule definitions: word geometry, controller states and
// the rotate/shift amounts of the two small sigma functions.
package sha256_msg_schedule_pkg;

   localparam int WORD_W    = 32;
   localparam int BLK_WORDS = 16;
   localparam int IDX_W     = 6;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int SIG0_ROT_A = 7;
   localparam int SIG0_ROT_B = 18;
   localparam int SIG0_SHR   = 3;
   localparam int SIG1_ROT_A = 17;
   localparam int SIG1_ROT_B = 19;
   localparam int SIG1_SHR   = 10;

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Word streams around the schedule expander: message words in (m_*), schedule words out (w_*).
interface sha256_msg_schedule_if;
   import sha256_msg_schedule_pkg::*;

   logic              m_valid;
   logic              m_ready;
   word_t             m_data;
   logic              w_valid;
   logic              w_ready;
   word_t             w_data;
   logic [IDX_W-1:0]  w_idx;

   // master: the surrounding front-end / round core; slave: the expander
   modport master (
      output m_valid, m_data, w_ready,
      input  m_ready, w_valid, w_data, w_idx
   );

   modport slave (
      input  m_valid, m_data, w_ready,
      output m_ready, w_valid, w_data, w_idx
   );

endinterface

// File: rtl/sha256_msg_schedule_sigma.sv
// Combinational SHA-256 small sigma: rotr(A) ^ rotr(B) ^ shr(S), amounts set per instance.
module sha256_msg_schedule_sigma
   import sha256_msg_schedule_pkg::*;
#(
   parameter int ROT_A = SIG0_ROT_A,
   parameter int ROT_B = SIG0_ROT_B,
   parameter int SHR   = SIG0_SHR
) (
   input  word_t x,
   output word_t y
);

   assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads 16 words into a sliding window and
// streams W[0..NUM_ROUNDS-1], generating W[t>=16] as the window shifts.
module sha256_msg_schedule
   import sha256_msg_schedule_pkg::*;
#(
   parameter int NUM_ROUNDS = 64,
   parameter int BLK_WORDS  = sha256_msg_schedule_pkg::BLK_WORDS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   sha256_msg_schedule_if.slave         bus,
   output logic                         busy,
   output logic                         done
);

   localparam int CNT_W = $clog2(BLK_WORDS);
   localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(BLK_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS - 1);

   state_t            state;
   state_t            state_nxt;
   word_t             win [BLK_WORDS];
   logic [CNT_W-1:0]  load_cnt;
   logic [IDX_W-1:0]  t;
   logic              done_r;

   logic              m_fire;
   logic              w_fire;
   logic              last_fire;
   word_t             sig0;
   word_t             sig1;
   word_t             new_w;

   assign m_fire    = bus.m_valid && bus.m_ready;
   assign w_fire    = bus.w_valid && bus.w_ready;
   assign last_fire = w_fire && (t == LAST_IDX);

   // m_ready is held low while reset is applied, and for the whole of RUN
   assign bus.m_ready = rst_n && (state != RUN);
   assign bus.w_valid = (state == RUN);
   assign bus.w_data  = win[0];
   assign bus.w_idx   = t;
   assign busy        = (state != IDLE);
   assign done        = done_r;

   sha256_msg_schedule_sigma #(
      .ROT_A (SIG0_ROT_A),
      .ROT_B (SIG0_ROT_B),
      .SHR   (SIG0_SHR)
   ) u_sigma0 (
      .x (win[1]),
      .y (sig0)
   );

   sha256_msg_schedule_sigma #(
      .ROT_A (SIG1_ROT_A),
      .ROT_B (SIG1_ROT_B),
      .SHR   (SIG1_SHR)
   ) u_sigma1 (
      .x (win[BLK_WORDS-2]),
      .y (sig1)
   );

   // W[t+16] from W[t+14], W[t+9], W[t+1], W[t]; carries beyond bit 31 drop naturally
   assign new_w = sig1 + win[BLK_WORDS-7] + sig0 + win[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (m_fire) state_nxt = LOAD;
         LOAD:    if (m_fire && (load_cnt == LAST_LOAD)) state_nxt = RUN;
         RUN:     if (last_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_cnt <= '0;
         t        <= '0;
         done_r   <= 1'b0;
         for (int i = 0; i < BLK_WORDS; i++) begin
            win[i] <= '0;
         end
      end else begin
         done_r <= last_fire;
         // load and shift never overlap: m_ready is low whenever w_valid is high
         if (m_fire) begin
            win[load_cnt] <= bus.m_data;
            load_cnt      <= (load_cnt == LAST_LOAD) ? '0 : load_cnt + 1'b1;
         end
         if (w_fire) begin
            for (int i = 0; i < BLK_WORDS - 1; i++) begin
               win[i] <= win[i+1];
            end
            win[BLK_WORDS-1] <= new_w;
            t <= last_fire ? '0 : t + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for the SHA-256 schedule expander: "abc", throttled, gapped,
// reset mid-block, back-to-back blocks and m_valid held during RUN.
module tb_sha256_msg_schedule;
   import sha256_msg_schedule_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic done;

   always #5 clk = ~clk;

   sha256_msg_schedule_if bus ();

   sha256_msg_schedule dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy),
      .done  (done)
   );

   int    n_checks = 0;
   int    n_pass   = 0;
   word_t blk   [16];
   word_t exp_w [64];
   word_t obs_w [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic word_t ssig0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic word_t ssig1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   task automatic build_model();
      for (int k = 0; k < 16; k++) exp_w[k] = blk[k];
      for (int k = 16; k < 64; k++)
         exp_w[k] = ssig1(exp_w[k-2]) + exp_w[k-7] + ssig0(exp_w[k-15]) + exp_w[k-16];
   endtask

   task automatic set_abc();
      for (int k = 0; k < 16; k++) blk[k] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      build_model();
   endtask

   // All tasks start and finish at a falling edge; inputs change only there.
   task automatic send_word(input word_t x);
      int n = 0;
      bus.m_valid = 1'b1;
      bus.m_data  = x;
      while (!bus.m_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.m_ready) check("m_ready_timeout", 32'(bus.m_ready), 32'd1);
      @(negedge clk);
      bus.m_valid = 1'b0;
   endtask

   task automatic load_block(input int gap, input int first);
      for (int k = first; k < 16; k++) begin
         if (k == 15 && gap > 0) check("wvalid_before_last", 32'(bus.w_valid), 32'd0);
         send_word(blk[k]);
         if (k < 15) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic collect(input int n, input bit throttle, input bit mready_low, input bit expect_done);
      int    got = 0;
      int    cyc = 0;
      bit    stall = 1'b0;
      word_t pd = '0;
      logic [IDX_W-1:0] pi = '0;
      while (got < n && cyc < 2000) begin
         bus.w_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            check("stall_valid", 32'(bus.w_valid), 32'd1);
            check("stall_data", bus.w_data, pd);
            check("stall_idx", 32'(bus.w_idx), 32'(pi));
         end
         if (mready_low) check("mready_in_run", 32'(bus.m_ready), 32'd0);
         if (bus.w_valid && bus.w_ready) begin
            check($sformatf("w%0d", got), bus.w_data, exp_w[got]);
            check($sformatf("idx%0d", got), 32'(bus.w_idx), 32'(got));
            obs_w[got] = bus.w_data;
            got++;
            stall = 1'b0;
         end else begin
            stall = bus.w_valid;
            pd    = bus.w_data;
            pi    = bus.w_idx;
         end
         @(negedge clk);
         cyc++;
      end
      if (got < n) check("collect_timeout", 32'(got), 32'(n));
      if (expect_done) begin
         check("done_pulse", 32'(done), 32'd1);
         check("done_wvalid", 32'(bus.w_valid), 32'd0);
         check("done_busy", 32'(busy), 32'd0);
         check("done_mready", 32'(bus.m_ready), 32'd1);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.w_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mready", 32'(bus.m_ready), 32'd0);
      check("rst_wvalid", 32'(bus.w_valid), 32'd0);
      check("rst_wdata", bus.w_data, 32'd0);
      check("rst_widx", 32'(bus.w_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_mready", 32'(bus.m_ready), 32'd1);

      // 1: "abc" block, core always ready
      set_abc();
      load_block(0, 0);
      collect(64, 1'b0, 1'b0, 1'b1);
      check("abc_w16", obs_w[16], 32'h61626380);
      check("abc_w17", obs_w[17], 32'h000F0000);
      check("abc_w18", obs_w[18], 32'h7DA86405);
      check("abc_w19", obs_w[19], 32'h600003C6);
      check("abc_w63", obs_w[63], 32'h12B1EDEB);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);

      // 2: random back-pressure
      load_block(0, 0);
      collect(64, 1'b1, 1'b0, 1'b1);
      check("thr_w63", obs_w[63], 32'h12B1EDEB);
      @(negedge clk);

      // 3: bubbles between input words
      load_block(2, 0);
      check("wvalid_rise", 32'(bus.w_valid), 32'd1);
      check("first_idx", 32'(bus.w_idx), 32'd0);
      collect(64, 1'b0, 1'b0, 1'b1);
      check("gap_w18", obs_w[18], 32'h7DA86405);
      @(negedge clk);

      // 4: reset at w_idx=30, then an all-ones block
      load_block(0, 0);
      collect(30, 1'b0, 1'b0, 1'b0);
      check("idx_at_30", 32'(bus.w_idx), 32'd30);
      bus.w_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_wvalid", 32'(bus.w_valid), 32'd0);
      check("mid_rst_wdata", bus.w_data, 32'd0);
      check("mid_rst_widx", 32'(bus.w_idx), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_mready", 32'(bus.m_ready), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 16; k++) blk[k] = 32'hFFFFFFFF;
      build_model();
      load_block(0, 0);
      collect(64, 1'b0, 1'b0, 1'b1);
      check("ones_w0", obs_w[0], 32'hFFFFFFFF);
      check("ones_w15", obs_w[15], 32'hFFFFFFFF);

      // 5: block 2's first word offered in the done cycle
      @(negedge clk);
      set_abc();
      load_block(0, 0);
      collect(64, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 16; k++) blk[k] = 32'h01234567 + 32'(k) * 32'h11111111;
      build_model();
      send_word(blk[0]);
      check("b2_first_taken", 32'(busy), 32'd1);
      load_block(0, 1);
      collect(64, 1'b1, 1'b0, 1'b1);
      @(negedge clk);

      // 6: m_valid held high throughout RUN
      set_abc();
      load_block(0, 0);
      bus.m_valid = 1'b1;
      bus.m_data  = 32'hDEADBEEF;
      collect(64, 1'b0, 1'b1, 1'b1);
      bus.m_valid = 1'b0;
      @(negedge clk);
      check("after_hold_busy", 32'(busy), 32'd0);
      check("hold_w63", obs_w[63], 32'h12B1EDEB);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0x%08h expected 0x%08h", n_checks, 0);
      $fatal(1, "timeout");
   end

endmodule
